sseg_field_display: RTL and testbench

Parametrised seven-segment field viewer for the virtual DE10-Lite board. Selects one of FIELDS hex values (operands, result), shows it as FIELD_W/4 hex digits plus a tag digit, and adds freeze, leading-zero blanking and a blinking edit cursor. Outputs are registered, active-low segment vectors that drive the board HEX displays directly.

---
 rtl/sseg_pkg.sv | 18 +
 rtl/sseg_blink_timer.sv | 35 +++
 rtl/sseg_field_display.sv | 102 ++++++++++
 tb/tb_sseg_field_display.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Seven-segment helpers shared by the field display.
// Active-low gfedcba encodings, bit 0 = segment a.
package sseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    return HEX_SEG[h];
  endfunction

endpackage

// File: rtl/sseg_blink_timer.sv
// Cursor blink timer: half-period counter with phase toggle.
// A restart forces the visible phase and clears the count.
module sseg_blink_timer #(
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic blink_phase
);

  localparam int CNTW = $clog2(BLINK_HALF);

  logic [CNTW-1:0] r_cnt;
  logic            r_phase;

  // count half-periods; restart beats a simultaneous wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (restart) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == CNTW'(BLINK_HALF - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNTW'(1);
    end
  end

  assign blink_phase = r_phase;

endmodule

// File: rtl/sseg_field_display.sv
// Field viewer: snapshot stage, blanking, registered segments.
// Digits 0..NIB-1 are nibbles, digit NIB shows the field tag.
module sseg_field_display
  import sseg_pkg::*;
#(
  parameter  int FIELDS     = 2,
  parameter  int FIELD_W    = 8,
  parameter  int BLINK_HALF = 12_500_000,
  parameter  int LZB        = 1,
  localparam int NIB        = FIELD_W / 4,
  localparam int SW         = (FIELDS > 1) ? $clog2(FIELDS) : 1,
  localparam int CW         = (NIB > 1) ? $clog2(NIB) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [FIELDS*FIELD_W-1:0] fields,
  input  logic [SW-1:0]             sel,
  input  logic                      edit_en,
  input  logic [CW-1:0]             cursor,
  input  logic                      freeze,
  output logic [(NIB+1)*7-1:0]      seg,
  output logic                      blink_phase
);

  logic [FIELD_W-1:0]     r_snap;
  logic [SW-1:0]          r_tag;
  logic                   r_edit;
  logic [CW-1:0]          r_cursor;
  logic [(NIB+1)*7-1:0]   r_seg;

  logic [FIELD_W-1:0]     w_pick;
  logic                   w_restart;
  logic                   w_phase;
  logic [(NIB+1)*7-1:0]   w_seg;

  // field mux; out-of-range selects read as zero
  always_comb begin
    w_pick = '0;
    for (int k = 0; k < FIELDS; k++) begin
      if (int'(sel) == k) begin
        w_pick = fields[k*FIELD_W +: FIELD_W];
      end
    end
  end

  assign w_restart = edit_en & ~r_edit;

  // stage 1: snapshot unless frozen; edit controls always follow
  always_ff @(posedge clk) begin
    if (rst) begin
      r_snap   <= '0;
      r_tag    <= '0;
      r_edit   <= 1'b0;
      r_cursor <= '0;
    end else begin
      if (!freeze) begin
        r_snap <= w_pick;
        r_tag  <= sel;
      end
      r_edit   <= edit_en;
      r_cursor <= cursor;
    end
  end

  sseg_blink_timer #(
    .BLINK_HALF (BLINK_HALF)
  ) u_blink (
    .clk         (clk),
    .rst         (rst),
    .restart     (w_restart),
    .blink_phase (w_phase)
  );

  // per-digit decode with cursor and leading-zero blanking
  always_comb begin
    w_seg = '1;
    for (int d = 0; d < NIB; d++) begin
      if (r_edit && !w_phase && int'(r_cursor) == d) begin
        w_seg[d*7 +: 7] = SEG_BLANK;
      end else if (LZB != 0 && !r_edit && d != 0 &&
                   (r_snap >> (4*d)) == '0) begin
        w_seg[d*7 +: 7] = SEG_BLANK;
      end else begin
        w_seg[d*7 +: 7] = hex2seg(r_snap[4*d +: 4]);
      end
    end
    w_seg[NIB*7 +: 7] = hex2seg(4'(r_tag));
  end

  // output register, blank out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= '1;
    end else begin
      r_seg <= w_seg;
    end
  end

  assign seg         = r_seg;
  assign blink_phase = w_phase;

endmodule

// File: tb/tb_sseg_field_display.sv
// Randomised scoreboard bench for sseg_field_display.
// Three 12-bit fields so cursor and select can exceed range.
module tb_sseg_field_display;

  localparam int FIELDS = 3;
  localparam int FW     = 12;
  localparam int BH     = 4;
  localparam int LZB    = 1;
  localparam int NIB    = FW / 4;
  localparam int SEGW   = (NIB + 1) * 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [FIELDS*FW-1:0] fields;
  logic [1:0]           sel;
  logic                 edit_en;
  logic [1:0]           cursor;
  logic                 freeze;
  logic [SEGW-1:0]      seg;
  logic                 blink_phase;

  sseg_field_display #(
    .FIELDS     (FIELDS),
    .FIELD_W    (FW),
    .BLINK_HALF (BH),
    .LZB        (LZB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fields      (fields),
    .sel         (sel),
    .edit_en     (edit_en),
    .cursor      (cursor),
    .freeze      (freeze),
    .seg         (seg),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SEGW-1:0] seg;
    logic            ph;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   running = 1'b1;

  logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // reference state: what is shown, and when the blink last restarted
  int m_val, m_tag, m_cur, t0, cyc;
  bit m_edit, m_phase;

  function automatic logic [SEGW-1:0] show(int v, int tag, bit ed,
                                           int cur, bit ph);
    logic [SEGW-1:0] s;
    int top;
    top = 0;
    for (int d = 0; d < NIB; d++)
      if (((v >> (4*d)) & 15) != 0) top = d;
    for (int d = 0; d < NIB; d++) begin
      if (ed && !ph && cur == d)
        s[d*7 +: 7] = 7'h7F;
      else if (LZB == 1 && !ed && d > top)
        s[d*7 +: 7] = 7'h7F;
      else
        s[d*7 +: 7] = HEX[(v >> (4*d)) & 15];
    end
    s[NIB*7 +: 7] = HEX[tag & 15];
    return s;
  endfunction

  task automatic step(bit r, logic [FIELDS*FW-1:0] f, int s, bit e,
                      int c, bit fz);
    exp_t x;
    rst = r; fields = f; sel = 2'(s);
    edit_en = e; cursor = 2'(c); freeze = fz;
    cyc++;
    if (r) x.seg = '1;
    else   x.seg = show(m_val, m_tag, m_edit, m_cur, m_phase);
    if (r) begin
      m_val = 0; m_tag = 0; m_edit = 0; m_cur = 0; t0 = cyc;
    end else begin
      if (!fz) begin
        m_val = (s < FIELDS) ? int'((f >> (s*FW)) & 12'hFFF) : 0;
        m_tag = s;
      end
      if (e && !m_edit) t0 = cyc;
      m_edit = e;
      m_cur  = c;
    end
    m_phase = (((cyc - t0) / BH) % 2) == 0;
    x.ph = m_phase;
    q.push_back(x);
    @(negedge clk);
  endtask

  // monitor: one output per clock, popped and compared
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
        if (running) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard_empty at %0t", $time);
        end
      end else begin
        x = q.pop_front();
        n_chk++;
        if (seg !== x.seg) begin
          n_fail++;
          $display("FAIL seg at %0t: got %h want %h", $time, seg, x.seg);
        end
        n_chk++;
        if (blink_phase !== x.ph) begin
          n_fail++;
          $display("FAIL blink_phase at %0t: got %b want %b",
                   $time, blink_phase, x.ph);
        end
      end
    end
  end

  initial begin
    logic [FIELDS*FW-1:0] F, G;
    int s, c;
    bit e, fz;
    m_val = 0; m_tag = 0; m_cur = 0; m_edit = 0; m_phase = 1;
    t0 = 0; cyc = 0;
    F = {12'h000, 12'h005, 12'h03C};
    G = {12'hFFF, 12'hFFF, 12'hFFF};
    repeat (2) step(1, F, 0, 0, 0, 0);
    repeat (3) step(0, F, 0, 0, 0, 0);
    repeat (3) step(0, F, 1, 0, 0, 0);
    repeat (20) step(0, F, 1, 1, 1, 0);
    step(0, F, 1, 0, 1, 0);
    repeat (6) step(0, F, 1, 1, 1, 0);
    step(0, F, 1, 0, 1, 0);
    repeat (5) step(0, F, 1, 1, 1, 0);
    repeat (2) step(0, F, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, G, (i % 2) * 2, 0, 0, 1);
    repeat (4) step(0, G, 0, 0, 0, 0);
    repeat (12) step(0, F, 0, 1, 3, 0);
    repeat (3) step(0, F, 3, 0, 0, 0);
    repeat (3) step(0, F, 2, 0, 0, 0);
    repeat (6) step(0, F, 0, 1, 0, 0);
    repeat (2) step(0, G, 1, 1, 0, 1);
    step(1, G, 1, 1, 0, 1);
    repeat (3) step(0, G, 1, 1, 0, 1);
    s = 0; c = 0; e = 0; fz = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < FIELDS * NIB; k++)
        F[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 3) == 0)  s  = $urandom_range(0, 3);
      if ($urandom_range(0, 11) == 0) e  = ~e;
      if ($urandom_range(0, 5) == 0)  fz = ~fz;
      if ($urandom_range(0, 7) == 0)  c  = $urandom_range(0, 3);
      step($urandom_range(0, 199) == 0, F, s, e, c, fz);
    end
    running = 1'b0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard_left %0d entries, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
